// File: rtl/fifo_wr_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : fifo_ctrl_pkg                                              |
// | Brief   : Shared types and helpers for the FIFO write-port arbiter.  |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package fifo_ctrl_pkg;

    localparam int DATA_W_DEF = 128;

    typedef enum logic {IDLE, BURST} arb_state_t;

    typedef logic [DATA_W_DEF-1:0] fifo_word_t;

    // Next index in a ring of n requesters.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_wr_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : fifo_wr_arbiter_if                                         |
// | Brief   : Producer handshake bus and FIFO write-side signals.        |
// |           master = producers/FIFO side, slave = arbiter.             |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
interface fifo_wr_arbiter_if
    import fifo_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = DATA_W_DEF
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_last;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      o_full;
    logic                      o_alm_full;
    logic                      i_wren;
    logic [DATA_W-1:0]         i_wrdata;
    logic [ID_W-1:0]           grant_id;
    logic                      busy;

    modport master (
        output req_valid, req_last, req_data, o_full, o_alm_full,
        input  req_ready, i_wren, i_wrdata, grant_id, busy
    );

    modport slave (
        input  req_valid, req_last, req_data, o_full, o_alm_full,
        output req_ready, i_wren, i_wrdata, grant_id, busy
    );

endinterface
`default_nettype wire

// File: rtl/fifo_wr_arbiter_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : fifo_rr_pick                                               |
// | Brief   : Combinational round-robin pick: first valid requester at   |
// |           or after rr_ptr, wrapping, plus an any-valid flag.         |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module fifo_rr_pick
    import fifo_ctrl_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  wire logic [NUM_REQ-1:0] req_valid,
    input  wire logic [ID_W-1:0]    rr_ptr,
    output logic      [ID_W-1:0]    pick_idx,
    output logic                    any_valid
);

    int w_idx;

    // Walk the ring starting at rr_ptr; the first hit wins.
    always_comb begin
        pick_idx  = '0;
        any_valid = 1'b0;
        w_idx     = int'(rr_ptr);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!any_valid && req_valid[ID_W'(w_idx)]) begin
                any_valid = 1'b1;
                pick_idx  = ID_W'(w_idx);
            end
            w_idx = rr_next(w_idx, NUM_REQ);
        end
    end

endmodule
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : fifo_wr_arbiter                                            |
// | Brief   : Shares the FIFO write port among NUM_REQ producers with    |
// |           round-robin, burst-capped grants and full/almost-full      |
// |           throttling. Write enable/data are registered.              |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module fifo_wr_arbiter
    import fifo_ctrl_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MAX_BURST = 8
) (
    input wire logic        clk,
    input wire logic        rst_n,
    fifo_wr_arbiter_if.slave bus
);

    localparam int ID_W = $clog2(NUM_REQ);
    localparam int BC_W = $clog2(MAX_BURST + 1);

    localparam logic [BC_W-1:0] C_LAST_BEAT = BC_W'(MAX_BURST - 1);

    arb_state_t          r_state;
    arb_state_t          w_state_nxt;
    logic [ID_W-1:0]     r_grant_id;
    logic [ID_W-1:0]     w_grant_nxt;
    logic [ID_W-1:0]     r_rr_ptr;
    logic [ID_W-1:0]     w_rr_ptr_nxt;
    logic [ID_W-1:0]     w_pick_idx;
    logic [BC_W-1:0]     r_beat_cnt;
    logic [BC_W-1:0]     w_beat_cnt_nxt;
    logic                w_any_valid;
    logic                w_can_wr;
    logic                w_accept;
    logic                w_sel_valid;
    logic                w_sel_last;
    logic [DATA_W-1:0]   w_sel_data;
    logic [NUM_REQ-1:0]  w_ready;
    logic                r_wren;
    logic [DATA_W-1:0]   r_wrdata;

    fifo_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req_valid (bus.req_valid),
        .rr_ptr    (r_rr_ptr),
        .pick_idx  (w_pick_idx),
        .any_valid (w_any_valid)
    );

    // Select the granted producer's valid/last/data.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b0;
        w_sel_data  = '0;
        for (int n = 0; n < NUM_REQ; n++) begin
            if (r_grant_id == ID_W'(n)) begin
                w_sel_valid = bus.req_valid[n];
                w_sel_last  = bus.req_last[n];
                w_sel_data  = bus.req_data[n*DATA_W +: DATA_W];
            end
        end
    end

    // Under almost-full only one write may be in flight, covering the
    // one-cycle registered write latency.
    assign w_can_wr = !bus.o_full && (!bus.o_alm_full || !r_wren);
    assign w_accept = (r_state == BURST) && w_sel_valid && w_can_wr;

    // Next-state, grant bookkeeping and ready generation.
    always_comb begin
        w_state_nxt    = r_state;
        w_grant_nxt    = r_grant_id;
        w_beat_cnt_nxt = r_beat_cnt;
        w_rr_ptr_nxt   = r_rr_ptr;
        w_ready        = '0;
        case (r_state)
            IDLE: begin
                if (w_any_valid) begin
                    w_state_nxt    = BURST;
                    w_grant_nxt    = w_pick_idx;
                    w_beat_cnt_nxt = '0;
                end
            end
            BURST: begin
                w_ready[r_grant_id] = w_can_wr;
                if (!w_sel_valid) begin
                    w_state_nxt  = IDLE;
                    w_rr_ptr_nxt = ID_W'(rr_next(int'(r_grant_id), NUM_REQ));
                end else if (w_accept) begin
                    w_beat_cnt_nxt = r_beat_cnt + 1'b1;
                    if (w_sel_last || (r_beat_cnt == C_LAST_BEAT)) begin
                        w_state_nxt  = IDLE;
                        w_rr_ptr_nxt = ID_W'(rr_next(int'(r_grant_id), NUM_REQ));
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Grant, beat counter and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant_id <= '0;
            r_beat_cnt <= '0;
            r_rr_ptr   <= '0;
        end else begin
            r_grant_id <= w_grant_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
        end
    end

    // FIFO write register: one pulse per accepted word, data held otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wren   <= 1'b0;
            r_wrdata <= '0;
        end else begin
            r_wren <= w_accept;
            if (w_accept) begin
                r_wrdata <= w_sel_data;
            end
        end
    end

    assign bus.req_ready = w_ready;
    assign bus.busy      = (r_state == BURST);
    assign bus.grant_id  = r_grant_id;
    assign bus.i_wren    = r_wren;
    assign bus.i_wrdata  = r_wrdata;

endmodule
`default_nettype wire
